// File: rtl/td4_regfile_gen_if.sv
// Bus between the TD4 decoder/ALU side (master) and the register file (slave).
// Optional STALL input exists only when REGFILE_STALL_EN is defined.
interface td4_regfile_gen_if #(
  parameter int WIDTH = 4,
  parameter int NREG  = 2
);
  localparam int RSW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NREG+1:0]      LOAD;
  logic [WIDTH-1:0]     IN_DATA;
`ifdef REGFILE_STALL_EN
  logic                 STALL;
`endif
  logic                 CARRY_IN;
  logic [RSW-1:0]       RD_SEL;
  logic [NREG*WIDTH-1:0] OUT_REG;
  logic [WIDTH-1:0]     OUT_RD;
  logic [WIDTH-1:0]     OUT_LD;
  logic [WIDTH-1:0]     ADDRESS;
  logic                 CARRY;
  logic                 WRAP;

  modport master (
    output LOAD, IN_DATA,
`ifdef REGFILE_STALL_EN
    output STALL,
`endif
    output CARRY_IN, RD_SEL,
    input  OUT_REG, OUT_RD, OUT_LD, ADDRESS, CARRY, WRAP
  );

  modport slave (
    input  LOAD, IN_DATA,
`ifdef REGFILE_STALL_EN
    input  STALL,
`endif
    input  CARRY_IN, RD_SEL,
    output OUT_REG, OUT_RD, OUT_LD, ADDRESS, CARRY, WRAP
  );
endinterface

// File: rtl/td4_regfile_gen.sv
// TD4 register file, output latch, program counter and carry flag.
// Define REGFILE_STALL_EN to add the STALL input that freezes all state updates.
module td4_regfile_gen #(
  parameter int WIDTH = 4,
  parameter int NREG  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  td4_regfile_gen_if.slave  bus
);
  localparam int RSW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             carry_q, carry_d;
  logic             wrap_q, wrap_d;
  logic             en;
  logic [WIDTH-1:0] rd_mux;

`ifdef REGFILE_STALL_EN
  assign en = !bus.STALL;
`else
  assign en = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    ld_d    = ld_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    wrap_d  = 1'b0;
    if (en) begin
      for (int i = 0; i < NREG; i++) begin
        if (!bus.LOAD[i]) regs_d[i] = bus.IN_DATA;
      end
      if (!bus.LOAD[NREG]) ld_d = bus.IN_DATA;
      // Jump wins over increment; only an increment out of all-ones counts as a wrap.
      if (!bus.LOAD[NREG+1]) begin
        pc_d = bus.IN_DATA;
      end else begin
        pc_d   = pc_q + WIDTH'(1);
        wrap_d = (pc_q == {WIDTH{1'b1}});
      end
      carry_d = bus.CARRY_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      ld_q    <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ld_q    <= ld_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      wrap_q  <= wrap_d;
    end
  end

  // Read port has no bypass; out-of-range selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.RD_SEL == RSW'(i)) rd_mux = regs_q[i];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_out_reg
    assign bus.OUT_REG[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign bus.OUT_RD  = rd_mux;
  assign bus.OUT_LD  = ld_q;
  assign bus.ADDRESS = pc_q;
  assign bus.CARRY   = carry_q;
  assign bus.WRAP    = wrap_q;
endmodule

// File: tb/tb_td4_regfile_gen.sv
// Directed bench for td4_regfile_gen (WIDTH=4, NREG=3) with a reference model
// feeding an expected-state queue; stall steps run when REGFILE_STALL_EN is defined.
module tb_td4_regfile_gen;
  localparam int WIDTH = 4;
  localparam int NREG  = 3;
  localparam int RSW   = 2;
  localparam int EW    = NREG*WIDTH + 2*WIDTH + 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  td4_regfile_gen_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  td4_regfile_gen #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [WIDTH-1:0] m_regs [NREG];
  logic [WIDTH-1:0] m_ld, m_pc;
  logic             m_carry, m_wrap;
  logic [EW-1:0]    exp_q [$];
  int               checks, errors;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_ld = '0; m_pc = '0; m_carry = 1'b0; m_wrap = 1'b0;
  endtask

  function automatic logic [EW-1:0] pack_model();
    logic [NREG*WIDTH-1:0] r;
    for (int i = 0; i < NREG; i++) r[i*WIDTH +: WIDTH] = m_regs[i];
    return {r, m_ld, m_pc, m_carry, m_wrap};
  endfunction

  function automatic logic [WIDTH-1:0] rd_model(input logic [RSW-1:0] s);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) if (s == RSW'(i)) v = m_regs[i];
    return v;
  endfunction

  task automatic check_state(input string tag, input logic [EW-1:0] e);
    check({tag, ".out_reg"}, 32'(bus.OUT_REG), 32'(e[EW-1 -: NREG*WIDTH]));
    check({tag, ".out_ld"},  32'(bus.OUT_LD),  32'(e[2*WIDTH+1 -: WIDTH]));
    check({tag, ".address"}, 32'(bus.ADDRESS), 32'(e[WIDTH+1 -: WIDTH]));
    check({tag, ".carry"},   32'(bus.CARRY),   32'(e[1]));
    check({tag, ".wrap"},    32'(bus.WRAP),    32'(e[0]));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic [NREG+1:0] load,
                      input logic [WIDTH-1:0] data, input logic cin, input logic stall);
    logic [EW-1:0] e;
    bus.LOAD     = load;
    bus.IN_DATA  = data;
    bus.CARRY_IN = cin;
`ifdef REGFILE_STALL_EN
    bus.STALL    = stall;
`endif
    #1;
    check({tag, ".rd_old"}, 32'(bus.OUT_RD), 32'(rd_model(bus.RD_SEL)));
    m_wrap = 1'b0;
    if (!stall) begin
      for (int i = 0; i < NREG; i++) if (!load[i]) m_regs[i] = data;
      if (!load[NREG]) m_ld = data;
      if (!load[NREG+1]) m_pc = data;
      else begin
        if (m_pc == 4'hF) m_wrap = 1'b1;
        m_pc = m_pc + 4'h1;
      end
      m_carry = cin;
    end
    exp_q.push_back(pack_model());
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check_state(tag, e);
    check({tag, ".rd_new"}, 32'(bus.OUT_RD), 32'(rd_model(bus.RD_SEL)));
  endtask

  localparam logic [NREG+1:0] IDLE = '1;

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b0;
    bus.LOAD = IDLE;
    bus.IN_DATA = '0;
    bus.CARRY_IN = 1'b0;
    bus.RD_SEL = '0;
`ifdef REGFILE_STALL_EN
    bus.STALL = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_state("reset", pack_model());
    check("reset.rd", 32'(bus.OUT_RD), 32'h0);

    RST = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step("count", IDLE, 4'h0, 1'b0, 1'b0);
      check("count.addr_k", 32'(bus.ADDRESS), 32'(k % 16));
      check("count.wrap_k", 32'(bus.WRAP), (k == 16) ? 32'h1 : 32'h0);
    end

    step("ld_r0", 5'b11110, 4'hA, 1'b0, 1'b0);
    step("ld_r1", 5'b11101, 4'hC, 1'b0, 1'b0);
    bus.RD_SEL = 2'd0; #1;
    check("rd_sel0", 32'(bus.OUT_RD), 32'hA);
    bus.RD_SEL = 2'd1; #1;
    check("rd_sel1", 32'(bus.OUT_RD), 32'hC);

    step("jump_multi", 5'b00111, 4'h7, 1'b0, 1'b0);
    check("jump_multi.addr", 32'(bus.ADDRESS), 32'h7);
    check("jump_multi.ld", 32'(bus.OUT_LD), 32'h7);
    check("jump_multi.regs", 32'(bus.OUT_REG), 32'h0CA);
    step("after_jump", IDLE, 4'h3, 1'b0, 1'b0);
    check("after_jump.addr", 32'(bus.ADDRESS), 32'h8);

    step("jump_f", 5'b01111, 4'hF, 1'b0, 1'b0);
    step("jump_0", 5'b01111, 4'h0, 1'b0, 1'b0);
    check("jump_0.wrap", 32'(bus.WRAP), 32'h0);
    step("post_jump0", IDLE, 4'h0, 1'b0, 1'b0);

    step("carry1", IDLE, 4'h0, 1'b1, 1'b0);
    check("carry1.val", 32'(bus.CARRY), 32'h1);
    step("carry0", IDLE, 4'h0, 1'b0, 1'b0);
    check("carry0.val", 32'(bus.CARRY), 32'h0);
    step("carry1b", IDLE, 4'h0, 1'b1, 1'b0);

    step("ld_r2", 5'b11011, 4'h5, 1'b1, 1'b0);
    bus.RD_SEL = 2'd2; #1;
    check("rd_sel2", 32'(bus.OUT_RD), 32'h5);
    bus.RD_SEL = 2'd3; #1;
    check("rd_sel3_oor", 32'(bus.OUT_RD), 32'h0);
    step("oor_hold", 5'b11110, 4'h9, 1'b0, 1'b0);
    bus.RD_SEL = 2'd0;

    step("to_8", 5'b01111, 4'h8, 1'b1, 1'b0);
    step("to_9", IDLE, 4'h0, 1'b1, 1'b0);
    check("to_9.addr", 32'(bus.ADDRESS), 32'h9);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_state("async_rst", pack_model());
    check("async_rst.addr", 32'(bus.ADDRESS), 32'h0);
    check("async_rst.rd", 32'(bus.OUT_RD), 32'h0);
    #1;
    RST = 1'b1;
    step("post_rst", IDLE, 4'h0, 1'b0, 1'b0);
    check("post_rst.addr", 32'(bus.ADDRESS), 32'h1);

`ifdef REGFILE_STALL_EN
    step("to_14", 5'b01111, 4'hE, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("stall", 5'b11110, 4'h6, 1'b1, 1'b1);
      check("stall.addr", 32'(bus.ADDRESS), 32'hE);
    end
    step("unstall", 5'b11110, 4'h6, 1'b1, 1'b0);
    check("unstall.addr", 32'(bus.ADDRESS), 32'hF);
    step("stall_wrap", IDLE, 4'h0, 1'b0, 1'b0);
    check("stall_wrap.wrap", 32'(bus.WRAP), 32'h1);
    step("stall_after", IDLE, 4'h0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
